// File: rtl/triple_circle.sv
// Streams the outline points of three overlapping midpoint circles whose
// centres are offsets of one input centre. One point per accepted cycle.
module triple_circle #(
   parameter int WIDTH = 32
) (
   input  logic                    _clock,
   input  logic                    _reset,
   input  logic                    _start,
   input  logic                    _ready,
   input  logic signed [WIDTH-1:0] centre_x,
   input  logic signed [WIDTH-1:0] centre_y,
   input  logic signed [WIDTH-1:0] radius,
   output logic                    _done,
   output logic                    _valid,
   output logic signed [WIDTH-1:0] _out0,
   output logic signed [WIDTH-1:0] _out1
);

   typedef logic signed [WIDTH-1:0] coord_t;

   typedef enum logic [2:0] {
      S_IDLE,
      S_INIT,
      S_EMIT,
      S_STEP,
      S_DONE
   } state_t;

   localparam coord_t C_ZERO  = coord_t'(0);
   localparam coord_t C_ONE   = coord_t'(1);
   localparam coord_t C_THREE = coord_t'(3);
   localparam coord_t C_SIX   = coord_t'(6);
   localparam coord_t C_TEN   = coord_t'(10);

   state_t     state, state_nx;
   coord_t     cx_q, cy_q, r_q;
   coord_t     sx_q, sy_q, x_q, y_q, d_q;
   logic [2:0] idx_q;
   logic [1:0] circ_q;

   logic   start_ok;
   logic   loop_go;
   coord_t x_inc, y_dec, d_pos, d_neg;
   coord_t sx_init, sy_init;

   assign start_ok = _start && ((state == S_IDLE) || (state == S_DONE));

   // One midpoint step; the decision update uses the already-advanced x and y.
   always_comb begin
      x_inc   = x_q + C_ONE;
      y_dec   = y_q - C_ONE;
      d_pos   = d_q + ((x_inc - y_dec) <<< 2) + C_TEN;
      d_neg   = d_q + (x_inc <<< 2) + C_SIX;
      loop_go = (y_q >= x_q);
   end

   always_comb begin
      sx_init = cx_q;
      sy_init = cy_q - (r_q >>> 2);
      case (circ_q)
         2'd0: begin
            sx_init = cx_q + (r_q >>> 1);
            sy_init = cy_q + (r_q >>> 2);
         end
         2'd1: begin
            sx_init = cx_q - (r_q >>> 1);
            sy_init = cy_q + (r_q >>> 2);
         end
         default: ;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values, independent of statement order.
   always_ff @(posedge _clock or negedge _reset) begin
      if (!_reset) state <= S_IDLE;
      else         state <= state_nx;
   end

   // NOTE: every signal written here gets a default first, so no path can
   // leave it unassigned and infer a latch.
   always_comb begin
      state_nx = state;
      case (state)
         S_IDLE, S_DONE: if (_start) state_nx = S_INIT;
         S_INIT:         state_nx = S_EMIT;
         S_EMIT:         if (_ready && (idx_q == 3'd7)) state_nx = S_STEP;
         S_STEP: begin
            if (loop_go)              state_nx = S_EMIT;
            else if (circ_q == 2'd2)  state_nx = S_DONE;
            else                      state_nx = S_INIT;
         end
         default:        state_nx = S_IDLE;
      endcase
   end

   // NOTE: the datapath is reset too; it is only a handful of registers and
   // it keeps the outputs and their source values defined out of reset.
   always_ff @(posedge _clock or negedge _reset) begin
      if (!_reset) begin
         cx_q   <= C_ZERO;
         cy_q   <= C_ZERO;
         r_q    <= C_ZERO;
         sx_q   <= C_ZERO;
         sy_q   <= C_ZERO;
         x_q    <= C_ZERO;
         y_q    <= C_ZERO;
         d_q    <= C_ZERO;
         idx_q  <= 3'd0;
         circ_q <= 2'd0;
      end else begin
         if (start_ok) begin
            cx_q   <= centre_x;
            cy_q   <= centre_y;
            r_q    <= radius;
            circ_q <= 2'd0;
         end
         case (state)
            S_INIT: begin
               sx_q  <= sx_init;
               sy_q  <= sy_init;
               x_q   <= C_ZERO;
               y_q   <= r_q;
               d_q   <= C_THREE - (r_q <<< 1);
               idx_q <= 3'd0;
            end
            S_EMIT: if (_ready) idx_q <= idx_q + 3'd1;
            S_STEP: begin
               if (loop_go) begin
                  x_q <= x_inc;
                  if (d_q > C_ZERO) begin
                     y_q <= y_dec;
                     d_q <= d_pos;
                  end else begin
                     d_q <= d_neg;
                  end
               end else begin
                  circ_q <= circ_q + 2'd1;
               end
            end
            default: ;
         endcase
      end
   end

   // Outputs decode straight from registered state, so they hold while stalled.
   always_comb begin
      _valid = (state == S_EMIT);
      _done  = (state == S_DONE);
      _out0  = C_ZERO;
      _out1  = C_ZERO;
      if (state == S_EMIT) begin
         case (idx_q)
            3'd0: begin _out0 = sx_q + x_q; _out1 = sy_q + y_q; end
            3'd1: begin _out0 = sx_q + x_q; _out1 = sy_q - y_q; end
            3'd2: begin _out0 = sx_q - x_q; _out1 = sy_q + y_q; end
            3'd3: begin _out0 = sx_q - x_q; _out1 = sy_q - y_q; end
            3'd4: begin _out0 = sx_q + y_q; _out1 = sy_q + x_q; end
            3'd5: begin _out0 = sx_q + y_q; _out1 = sy_q - x_q; end
            3'd6: begin _out0 = sx_q - y_q; _out1 = sy_q + x_q; end
            default: begin _out0 = sx_q - y_q; _out1 = sy_q - x_q; end
         endcase
      end
   end

endmodule

// File: tb/tb_triple_circle.sv
// Scoreboard bench for triple_circle: a reference midpoint model queues the
// expected points, a negedge monitor pops and compares delivered points.
module tb_triple_circle;

   typedef struct {
      int x;
      int y;
   } point_t;

   logic              _clock;
   logic              _reset;
   logic              _start;
   logic              _ready;
   logic signed [31:0] centre_x, centre_y, radius;
   logic              _done, _valid;
   logic signed [31:0] _out0, _out1;

   int     n_checks;
   int     n_fail;
   int     n_got;
   bit     rand_ready;
   bit     stall;
   int     hold_x, hold_y;
   point_t exp_q[$];
   int     log_x[$];
   int     log_y[$];

   triple_circle #(.WIDTH(32)) dut (
      ._clock  (_clock),
      ._reset  (_reset),
      ._start  (_start),
      ._ready  (_ready),
      .centre_x(centre_x),
      .centre_y(centre_y),
      .radius  (radius),
      ._done   (_done),
      ._valid  (_valid),
      ._out0   (_out0),
      ._out1   (_out1)
   );

   initial _clock = 1'b0;
   always #5 _clock = ~_clock;

   task automatic check(input string tag, input longint got, input longint exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic push_group(input int sx, input int sy, input int x, input int y);
      exp_q.push_back('{sx + x, sy + y});
      exp_q.push_back('{sx + x, sy - y});
      exp_q.push_back('{sx - x, sy + y});
      exp_q.push_back('{sx - x, sy - y});
      exp_q.push_back('{sx + y, sy + x});
      exp_q.push_back('{sx + y, sy - x});
      exp_q.push_back('{sx - y, sy + x});
      exp_q.push_back('{sx - y, sy - x});
   endtask

   task automatic push_run(input int cx, input int cy, input int r);
      int sx, sy, x, y, d;
      for (int c = 0; c < 3; c++) begin
         sx = (c == 0) ? cx + (r >>> 1) : (c == 1) ? cx - (r >>> 1) : cx;
         sy = (c == 2) ? cy - (r >>> 2) : cy + (r >>> 2);
         x = 0;
         y = r;
         d = 3 - 2 * r;
         push_group(sx, sy, x, y);
         while (y >= x) begin
            x++;
            if (d > 0) begin
               y--;
               d = d + 4 * (x - y) + 10;
            end else begin
               d = d + 4 * x + 6;
            end
            push_group(sx, sy, x, y);
         end
      end
   endtask

   // Consumer: new _ready value just after each rising edge.
   initial begin
      _ready = 1'b1;
      forever begin
         @(posedge _clock);
         #1;
         _ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      end
   end

   // Monitor: delivery happens on the next rising edge when valid && ready.
   always @(negedge _clock) begin
      if (!_reset) begin
         stall = 1'b0;
      end else begin
         if (stall) begin
            check("hold_valid", _valid, 1);
            check("hold_x", _out0, hold_x);
            check("hold_y", _out1, hold_y);
         end
         stall  = _valid && !_ready;
         hold_x = _out0;
         hold_y = _out1;
         if (_valid && _ready) begin
            if (exp_q.size() == 0) begin
               check("extra_point", 1, 0);
            end else begin
               point_t e;
               e = exp_q.pop_front();
               check("pt_x", _out0, e.x);
               check("pt_y", _out1, e.y);
            end
            log_x.push_back(_out0);
            log_y.push_back(_out1);
            n_got++;
         end
      end
   end

   task automatic pulse_start(input int cx, input int cy, input int r);
      @(posedge _clock);
      #1;
      centre_x = cx;
      centre_y = cy;
      radius   = r;
      _start   = 1'b1;
      @(posedge _clock);
      #1;
      _start = 1'b0;
      check("done_clr_after_start", _done, 0);
   endtask

   task automatic wait_points(input int n);
      int i;
      i = 0;
      while (n_got < n && i < 5000) begin
         @(negedge _clock);
         i++;
      end
      if (n_got < n) check("timeout_points", n_got, n);
   endtask

   task automatic wait_done();
      int i;
      i = 0;
      while (!_done && i < 20000) begin
         @(negedge _clock);
         i++;
      end
      check("done_seen", _done, 1);
   endtask

   task automatic start_run(input int cx, input int cy, input int r, output int n_exp);
      exp_q.delete();
      log_x.delete();
      log_y.delete();
      n_got = 0;
      push_run(cx, cy, r);
      n_exp = exp_q.size();
      pulse_start(cx, cy, r);
   endtask

   task automatic finish_run(input int n_exp);
      wait_done();
      check("valid_low_at_done", _valid, 0);
      check("queue_drained", exp_q.size(), 0);
      check("point_count", n_got, n_exp);
   endtask

   initial begin
      int n_exp;
      n_checks   = 0;
      n_fail     = 0;
      n_got      = 0;
      rand_ready = 1'b0;
      stall      = 1'b0;
      _start     = 1'b0;
      centre_x   = 0;
      centre_y   = 0;
      radius     = 0;
      _reset     = 1'b0;
      #12;
      check("rst_done", _done, 0);
      check("rst_valid", _valid, 0);
      check("rst_out0", _out0, 0);
      check("rst_out1", _out1, 0);
      #10 _reset = 1'b1;

      // Run 1: full-rate consumer.
      start_run(50, 50, 8, n_exp);
      check("model_count_168", n_exp, 168);
      finish_run(n_exp);
      if (log_x.size() >= 168) begin
         check("p0_x", log_x[0], 54);   check("p0_y", log_y[0], 60);
         check("p1_x", log_x[1], 54);   check("p1_y", log_y[1], 44);
         check("p4_x", log_x[4], 62);   check("p4_y", log_y[4], 52);
         check("p7_x", log_x[7], 46);   check("p7_y", log_y[7], 52);
         check("c2_first_x", log_x[56], 46);  check("c2_first_y", log_y[56], 60);
         check("c3_first_x", log_x[112], 50); check("c3_first_y", log_y[112], 56);
      end else begin
         check("run1_log_size", log_x.size(), 168);
      end

      // Run 2: same arguments, random backpressure.
      rand_ready = 1'b1;
      start_run(50, 50, 8, n_exp);
      finish_run(n_exp);
      rand_ready = 1'b0;

      // Back-to-back: second run issued from DONE.
      start_run(10, -5, 4, n_exp);
      finish_run(n_exp);
      if (log_x.size() > 0) begin
         check("r2_c1_x", log_x[0], 12);
         check("r2_c1_y", log_y[0], 0);
      end else begin
         check("r2_log_size", log_x.size(), n_exp);
      end

      // Radius zero at the origin.
      start_run(0, 0, 0, n_exp);
      finish_run(n_exp);
      check("r0_count", n_got, 48);
      if (log_x.size() >= 48) begin
         check("r0_g2_x", log_x[8], 1);
         check("r0_g2_y", log_y[8], -1);
         check("r0_c3_g2_x", log_x[40], 1);
         check("r0_c3_g2_y", log_y[40], -1);
      end

      // Reset in the middle of a run, then a clean full run.
      start_run(50, 50, 8, n_exp);
      wait_points(30);
      #2 _reset = 1'b0;
      #1;
      check("midrst_valid", _valid, 0);
      check("midrst_done", _done, 0);
      check("midrst_out0", _out0, 0);
      check("midrst_out1", _out1, 0);
      #20 _reset = 1'b1;
      start_run(50, 50, 8, n_exp);
      finish_run(n_exp);

      // A start pulse while busy is ignored.
      rand_ready = 1'b1;
      start_run(50, 50, 8, n_exp);
      wait_points(20);
      pulse_start(1, 2, 3);
      finish_run(n_exp);
      check("busy_start_count", n_got, 168);
      rand_ready = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
